// File: rtl/tge_pkg.sv
// Shared types and constants for the 10GbE transmit packetizer.
package tge_pkg;

    localparam int SEQ_WIDTH  = 48;
    localparam int SYNC_WIDTH = 16;
    localparam int HDR_WIDTH  = SYNC_WIDTH + SEQ_WIDTH;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_HEADER  = 2'd1,
        ST_PAYLOAD = 2'd2
    } tge_state_e;

    // Header word layout: sync pattern in the top bits, frame sequence below.
    function automatic logic [HDR_WIDTH-1:0] tge_header(
        input logic [SYNC_WIDTH-1:0] sync,
        input logic [SEQ_WIDTH-1:0]  seq
    );
        return {sync, seq};
    endfunction

endpackage

// File: rtl/tge_sync_fifo.sv
// Single-clock first-word-fall-through FIFO. The storage array has no reset
// and a registered read port so it maps onto block RAM; the read address is
// looked ahead by one so rd_data always shows the head word while not empty.
module tge_sync_fifo #(
    parameter  int WIDTH = 64,
    parameter  int DEPTH = 512,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic [CW-1:0]    count,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rd_data_q;
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_wr, do_rd;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_wr   = wr_en && !full;
    assign do_rd   = rd_en && !empty;
    assign count   = count_q;
    assign rd_data = rd_data_q;

    // Pointer and occupancy next-state.
    always_comb begin
        wr_ptr_d = wr_ptr_q + AW'(do_wr);
        rd_ptr_d = rd_ptr_q + AW'(do_rd);
        count_d  = count_q;
        case ({do_wr, do_rd})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // RAM write port.
    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    // Registered look-ahead read; bypass when the new head is being written now.
    always_ff @(posedge clk) begin
        if (do_wr && (wr_ptr_q == rd_ptr_d)) begin
            rd_data_q <= wr_data;
        end else begin
            rd_data_q <= mem_q[rd_ptr_d];
        end
    end

endmodule

// File: rtl/tge_packetizer.sv
// Frames the serializer word stream into fixed-length 10GbE TX frames.
// Optional header word enabled by defining TGE_PACKETIZER_HEADER_EN.
//
// state      | meaning
// -----------+---------------------------------------------------------
// ST_IDLE    | waiting for a full frame in the FIFO and tx_afull low
// ST_HEADER  | header word {SYNC_WORD, seq} on the TX outputs
// ST_PAYLOAD | payload word cnt_q on the TX outputs; eof at the last one
module tge_packetizer
    import tge_pkg::*;
#(
    parameter  int                    DATA_WIDTH    = 64,
    parameter  int                    PAYLOAD_WORDS = 128,
    parameter  int                    FIFO_DEPTH    = 512,
    parameter  logic [SYNC_WIDTH-1:0] SYNC_WORD     = 16'hA5A5,
    localparam int                    FILL_W        = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    input  logic                  tx_afull,
    output logic [DATA_WIDTH-1:0] tx_data,
    output logic                  tx_valid,
    output logic                  tx_eof,
    output logic                  overflow,
    output logic [FILL_W-1:0]     fill
);

    localparam int CNT_W = $clog2(PAYLOAD_WORDS);

    tge_state_e              state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [SEQ_WIDTH-1:0]    seq_q, seq_d;
    logic [DATA_WIDTH-1:0]   tx_data_q, tx_data_d;
    logic                    tx_valid_q, tx_valid_d;
    logic                    tx_eof_q, tx_eof_d;
    logic                    overflow_q, overflow_d;

    logic                    fifo_wr, fifo_rd;
    logic [DATA_WIDTH-1:0]   fifo_dout;
    logic [FILL_W-1:0]       fifo_count;
    logic                    fifo_full, fifo_empty;
    logic                    frame_go;
    logic [DATA_WIDTH-1:0]   hdr_word;
    logic                    unused_sig;

    // A word arriving while full is lost even if a read happens this cycle.
    assign fifo_wr    = in_valid && !fifo_full;
    assign overflow_d = overflow_q | (in_valid & fifo_full);
    assign frame_go   = (fifo_count >= FILL_W'(PAYLOAD_WORDS)) && !tx_afull;
    assign hdr_word   = DATA_WIDTH'(tge_header(SYNC_WORD, seq_q));

`ifdef TGE_PACKETIZER_HEADER_EN
    assign unused_sig = fifo_empty;
`else
    assign unused_sig = fifo_empty ^ (^hdr_word);
`endif

    tge_sync_fifo #(
        .WIDTH (DATA_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (fifo_wr),
        .wr_data (in_data),
        .rd_en   (fifo_rd),
        .rd_data (fifo_dout),
        .count   (fifo_count),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // Next state plus the next value of every registered TX output.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        seq_d      = seq_q;
        tx_data_d  = '0;
        tx_valid_d = 1'b0;
        tx_eof_d   = 1'b0;
        fifo_rd    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (frame_go) begin
`ifdef TGE_PACKETIZER_HEADER_EN
                    state_d    = ST_HEADER;
                    tx_data_d  = hdr_word;
                    tx_valid_d = 1'b1;
`else
                    state_d    = ST_PAYLOAD;
                    tx_data_d  = fifo_dout;
                    tx_valid_d = 1'b1;
                    fifo_rd    = 1'b1;
                    cnt_d      = '0;
`endif
                end
            end
`ifdef TGE_PACKETIZER_HEADER_EN
            ST_HEADER: begin
                state_d    = ST_PAYLOAD;
                tx_data_d  = fifo_dout;
                tx_valid_d = 1'b1;
                fifo_rd    = 1'b1;
                cnt_d      = '0;
            end
`endif
            ST_PAYLOAD: begin
                if (cnt_q == CNT_W'(PAYLOAD_WORDS - 1)) begin
                    // Last word is on the outputs now; force the idle gap.
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    seq_d   = seq_q + SEQ_WIDTH'(1);
                end else begin
                    tx_data_d  = fifo_dout;
                    tx_valid_d = 1'b1;
                    fifo_rd    = 1'b1;
                    cnt_d      = cnt_q + CNT_W'(1);
                    tx_eof_d   = (cnt_q == CNT_W'(PAYLOAD_WORDS - 2));
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            seq_q      <= '0;
            tx_data_q  <= '0;
            tx_valid_q <= 1'b0;
            tx_eof_q   <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            seq_q      <= seq_d;
            tx_data_q  <= tx_data_d;
            tx_valid_q <= tx_valid_d;
            tx_eof_q   <= tx_eof_d;
            overflow_q <= overflow_d;
        end
    end

    assign tx_data  = tx_data_q;
    assign tx_valid = tx_valid_q;
    assign tx_eof   = tx_eof_q;
    assign overflow = overflow_q;
    assign fill     = fifo_count;

endmodule

// File: tb/tb_tge_packetizer.sv
// Testbench for tge_packetizer with PAYLOAD_WORDS=4, FIFO_DEPTH=8.
// Honours TGE_PACKETIZER_HEADER_EN the same way as the design.
module tb_tge_packetizer;

    localparam int PW    = 4;
    localparam int DEPTH = 8;
    localparam int DW    = 64;
    localparam int FW    = $clog2(DEPTH) + 1;
`ifdef TGE_PACKETIZER_HEADER_EN
    localparam int HDR = 1;
`else
    localparam int HDR = 0;
`endif
    localparam int FL = PW + HDR;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic          in_valid = 1'b0;
    logic          tx_afull = 1'b0;
    logic [DW-1:0] tx_data;
    logic          tx_valid;
    logic          tx_eof;
    logic          overflow;
    logic [FW-1:0] fill;

    always #5 clk = ~clk;

    tge_packetizer #(
        .DATA_WIDTH    (DW),
        .PAYLOAD_WORDS (PW),
        .FIFO_DEPTH    (DEPTH),
        .SYNC_WORD     (16'hA5A5)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_data  (in_data),
        .in_valid (in_valid),
        .tx_afull (tx_afull),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_eof   (tx_eof),
        .overflow (overflow),
        .fill     (fill)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard: accepted input words queue up; the monitor pops them.
    logic [63:0] pay_q[$];
    int          pos    = 0;
    logic [47:0] seq_m  = '0;
    bit          sb_en  = 1'b0;
    bit          gap_exp = 1'b0;
    int          frames = 0;

    always @(negedge clk) begin
        if (sb_en) begin
            if (tx_valid) begin
                if (gap_exp) chk("inter_frame_gap", tx_valid, 0);
                gap_exp = 1'b0;
`ifdef TGE_PACKETIZER_HEADER_EN
                if (pos == 0) chk("header", tx_data, {16'hA5A5, seq_m});
                else
`endif
                if (pay_q.size() == 0) chk("extra_word", tx_data, 64'hDEAD_DEAD_DEAD_DEAD);
                else chk("payload", tx_data, pay_q.pop_front());
                chk("eof", tx_eof, 64'(pos == FL - 1));
                pos++;
                if (pos == FL) begin
                    pos = 0;
                    seq_m++;
                    frames++;
                    gap_exp = 1'b1;
                end
            end else begin
                gap_exp = 1'b0;
                if (pos != 0) chk("gapless", tx_valid, 1);
                chk("eof_without_valid", tx_eof, 0);
            end
        end
    end

    task automatic drive(input logic v, input logic [63:0] d, input bit accept);
        @(negedge clk);
        in_valid = v;
        in_data  = d;
        if (v && accept) pay_q.push_back(d);
    endtask

    task automatic do_reset();
        @(negedge clk);
        sb_en    = 1'b0;
        rst      = 1'b0;
        in_valid = 1'b0;
        tx_afull = 1'b0;
        repeat (3) @(negedge clk);
        pay_q.delete();
        pos     = 0;
        seq_m   = '0;
        frames  = 0;
        gap_exp = 1'b0;
        rst     = 1'b1;
        sb_en   = 1'b1;
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while ((pay_q.size() != 0 || pos != 0) && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk(name, 64'(n < 300), 1);
    endtask

    typedef struct {
        logic        v;
        logic [63:0] d;
        logic        exp_valid;
        logic        exp_eof;
        logic [63:0] exp_data;
        logic [FW-1:0] exp_fill;
    } vec_t;

    function automatic vec_t mk(input logic v, input logic [63:0] d, input logic ev,
                                input logic ee, input logic [63:0] ed, input int ef);
        vec_t r;
        r.v = v; r.d = d; r.exp_valid = ev; r.exp_eof = ee; r.exp_data = ed;
        r.exp_fill = FW'(ef);
        return r;
    endfunction

    vec_t tbl[10];

    initial begin : main
        bit saw_valid;
        bit found;

        // Reset values
        repeat (2) @(negedge clk);
        chk("rst_tx_data", tx_data, 0);
        chk("rst_tx_valid", tx_valid, 0);
        chk("rst_tx_eof", tx_eof, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_fill", fill, 0);
        @(negedge clk);
        rst = 1'b1;

        // Single frame, cycle-exact: words 1..4 written back to back.
        tbl[0] = mk(1, 64'h1, 0, 0, 0, 1);
        tbl[1] = mk(1, 64'h2, 0, 0, 0, 2);
        tbl[2] = mk(1, 64'h3, 0, 0, 0, 3);
        tbl[3] = mk(1, 64'h4, 0, 0, 0, 4);
`ifdef TGE_PACKETIZER_HEADER_EN
        tbl[4] = mk(0, 0, 1, 0, 64'hA5A5_0000_0000_0000, 4);
        tbl[5] = mk(0, 0, 1, 0, 64'h1, 3);
        tbl[6] = mk(0, 0, 1, 0, 64'h2, 2);
        tbl[7] = mk(0, 0, 1, 0, 64'h3, 1);
        tbl[8] = mk(0, 0, 1, 1, 64'h4, 0);
        tbl[9] = mk(0, 0, 0, 0, 0, 0);
`else
        tbl[4] = mk(0, 0, 1, 0, 64'h1, 3);
        tbl[5] = mk(0, 0, 1, 0, 64'h2, 2);
        tbl[6] = mk(0, 0, 1, 0, 64'h3, 1);
        tbl[7] = mk(0, 0, 1, 1, 64'h4, 0);
        tbl[8] = mk(0, 0, 0, 0, 0, 0);
        tbl[9] = mk(0, 0, 0, 0, 0, 0);
`endif
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            in_valid = tbl[i].v;
            in_data  = tbl[i].d;
            @(posedge clk);
            #1;
            chk($sformatf("tbl%0d_valid", i), tx_valid, tbl[i].exp_valid);
            chk($sformatf("tbl%0d_eof", i), tx_eof, tbl[i].exp_eof);
            chk($sformatf("tbl%0d_fill", i), fill, tbl[i].exp_fill);
            if (tbl[i].exp_valid) chk($sformatf("tbl%0d_data", i), tx_data, tbl[i].exp_data);
        end

        // Bursty input 4 valid / 1 idle, three frames.
        do_reset();
        for (int f = 0; f < 3; f++) begin
            for (int k = 0; k < 4; k++) drive(1, 64'h100 + 64'(f * 4 + k), 1);
            drive(0, 0, 0);
        end
        wait_drain("burst_drain");
        chk("burst_frames", frames, 3);

        // tx_afull gating.
        do_reset();
        @(negedge clk);
        tx_afull = 1'b1;
        for (int k = 0; k < 8; k++) drive(1, 64'h200 + 64'(k), 1);
        drive(0, 0, 0);
        saw_valid = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (tx_valid) saw_valid = 1'b1;
        end
        chk("afull_no_valid", saw_valid, 0);
        chk("afull_fill", fill, 8);
        tx_afull = 1'b0;
        @(negedge clk);
        chk("afull_release_latency", tx_valid, 1);
        @(negedge clk);
        tx_afull = 1'b1;
        begin
            int n = 0;
            while (pos != 0 && n < 50) begin
                @(negedge clk);
                n++;
            end
            chk("afull_frame_end", 64'(n < 50), 1);
        end
        saw_valid = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if (tx_valid) saw_valid = 1'b1;
        end
        chk("afull_second_blocked", saw_valid, 0);
        chk("afull_fill_rest", fill, 4);
        tx_afull = 1'b0;
        wait_drain("afull_drain");
        chk("afull_frames", frames, 2);

        // Overflow: 10 writes into an 8-deep FIFO with TX blocked.
        do_reset();
        @(negedge clk);
        tx_afull = 1'b1;
        for (int k = 0; k < 10; k++) drive(1, 64'h300 + 64'(k), k < 8);
        drive(0, 0, 0);
        chk("ovf_fill", fill, 8);
        chk("ovf_flag", overflow, 1);
        repeat (5) @(negedge clk);
        chk("ovf_sticky", overflow, 1);
        tx_afull = 1'b0;
        wait_drain("ovf_drain");
        repeat (10) @(negedge clk);
        chk("ovf_frames", frames, 2);
        chk("ovf_sticky_after", overflow, 1);
        chk("ovf_fill_empty", fill, 0);

        // Reset during payload word 2, then a clean frame restarting at seq 0.
        do_reset();
        for (int k = 1; k <= 4; k++) drive(1, 64'h500 + 64'(k), 1);
        drive(0, 0, 0);
        found = 1'b0;
        for (int n = 0; n < 30 && !found; n++) begin
            @(negedge clk);
            if (tx_valid && tx_data == 64'h502) found = 1'b1;
        end
        chk("rstmid_found_word2", found, 1);
        sb_en = 1'b0;
        rst   = 1'b0;
        @(negedge clk);
        chk("rstmid_valid", tx_valid, 0);
        chk("rstmid_eof", tx_eof, 0);
        chk("rstmid_fill", fill, 0);
        @(negedge clk);
        pay_q.delete();
        pos     = 0;
        seq_m   = '0;
        frames  = 0;
        gap_exp = 1'b0;
        rst     = 1'b1;
        sb_en   = 1'b1;
        for (int k = 1; k <= 4; k++) drive(1, 64'h600 + 64'(k), 1);
        drive(0, 0, 0);
        wait_drain("rstmid_drain");
        chk("rstmid_frames", frames, 1);

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d failures=%0d", checks, failures);
        $fatal(1);
    end

endmodule
